// File: rtl/uart_rx_pkg.sv
// Shared constants, state encoding and baud-divider helper for the 8N1 UART receiver.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // Rounded divider so the bit period error stays within half a clock.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling, stop-bit check with
// one-cycle data_valid / frame_err strobes and a break state for held-low lines.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk_i(clk_25mhz),
    .rst_i(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + IDX_ONE;
            if (bit_idx_q == LAST_BIT) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          // Returning to IDLE mid-stop-bit leaves room for a back-to-back start edge.
          if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_BREAK: begin
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frame checks for uart_rx against a byte-level reference model.
`timescale 1ns / 1ps
module tb_uart_rx;

  localparam int  CPB      = 217;
  localparam real BIT_CLKS = 217.0;
  localparam int  LATENCY  = 2 + 108 + 9 * 217 + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int ferr_cnt = 0;
  int overlap = 0;
  int exp_ferr = 0;
  logic [7:0] exp_data = 8'h00;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk_25mhz (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid) begin
      got_q.push_back(data);
      got_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (data_valid && frame_err) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit edges placed by rounding cumulative time, so skewed rates stay accurate.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_bits,
                            input real bit_clks);
    int prev_edge = 0;
    for (int i = 0; i < 9 + stop_bits; i++) begin
      logic lv;
      int   edge_at;
      if (i == 0) lv = 1'b0;
      else if (i <= 8) lv = b[i-1];
      else lv = stop_v;
      rx = lv;
      if (i == 0) fall_cyc = cyc;
      edge_at = int'($rtoi((i + 1) * bit_clks + 0.5));
      wait_clks(edge_at - prev_edge);
      prev_edge = edge_at;
    end
  endtask

  task automatic good_frame(input logic [7:0] b, input real bit_clks);
    send_frame(b, 1'b1, 1, bit_clks);
    exp_q.push_back(b);
    exp_data = b;
  endtask

  task automatic expect_frames(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, got_q[i], exp_q[i]);
    chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk({tag, "_data_held"}, data, exp_data);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    int k;
    logic [7:0] rnd_a;
    logic [7:0] rnd_b;

    wait_clks(5);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    wait_clks(5);

    // Loopback pair with latency measurement on the first frame.
    good_frame(8'hA5, BIT_CLKS);
    wait_clks(300);
    lat = (got_cyc.size() > 0) ? got_cyc[0] - fall_cyc : -1000;
    chk("latency_in_window", (lat >= LATENCY - 1 && lat <= LATENCY + 1), 1);
    good_frame(8'h3C, BIT_CLKS);
    wait_clks(300);
    expect_frames("loopback");

    // Start-bit glitch.
    rx = 1'b0;
    wait_clks(50);
    rx = 1'b1;
    k = 0;
    while (busy && k < 110) begin
      wait_clks(1);
      k++;
    end
    chk("glitch_busy_low", busy, 1'b0);
    wait_clks(300);
    expect_frames("glitch_quiet");
    good_frame(8'h81, BIT_CLKS);
    wait_clks(300);
    expect_frames("after_glitch");

    // Framing error with a line held low for three bit times.
    send_frame(8'h5A, 1'b0, 3, BIT_CLKS);
    exp_ferr++;
    chk("break_busy", busy, 1'b1);
    rx = 1'b1;
    wait_clks(300);
    chk("break_released", busy, 1'b0);
    expect_frames("frame_err");
    good_frame(8'h12, BIT_CLKS);
    wait_clks(300);
    expect_frames("after_break");

    // Back-to-back frames with no idle between stop and next start.
    good_frame(8'h00, BIT_CLKS);
    good_frame(8'hFF, BIT_CLKS);
    wait_clks(300);
    lat = (got_cyc.size() > 1) ? got_cyc[1] - got_cyc[0] : -1000;
    chk("b2b_spacing", (lat >= 10 * CPB - 1 && lat <= 10 * CPB + 1), 1);
    expect_frames("back_to_back");

    // Reset during bit 4 of 0x77; the transmitter side idles high while reset.
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h77 >> i) & 8'h01;
      wait_clks(CPB);
    end
    rx = 1'b1;
    wait_clks(100);
    reset = 1'b1;
    wait_clks(2);
    chk("midrst_data", data, 8'h00);
    chk("midrst_valid", data_valid, 1'b0);
    chk("midrst_ferr", frame_err, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    exp_data = 8'h00;
    wait_clks(2500);
    expect_frames("midrst_quiet");
    good_frame(8'hC3, BIT_CLKS);
    wait_clks(300);
    expect_frames("after_reset");

    // +/-3% baud skew.
    good_frame(8'h96, BIT_CLKS / 1.03);
    wait_clks(300);
    good_frame(8'h96, BIT_CLKS / 0.97);
    wait_clks(300);
    expect_frames("baud_skew");

    // Random bytes, back-to-back, at random skew inside the tolerance.
    for (int i = 0; i < 3; i++) begin
      rnd_a = 8'($urandom_range(0, 255));
      rnd_b = 8'($urandom_range(0, 255));
      good_frame(rnd_a, BIT_CLKS * (0.98 + 0.01 * $urandom_range(0, 4)));
      good_frame(rnd_b, BIT_CLKS);
      wait_clks(300);
      expect_frames("random");
    end

    chk("no_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
